// File: rtl/sd_pkg.sv
// Shared definitions for the word scheduler and its "1011" detector core.
package sd_pkg;
   localparam int NREQ_DEF   = 4;
   localparam int WORD_W_DEF = 8;
   localparam int CNT_W_DEF  = 4;

   localparam logic [3:0] PATTERN = 4'b1011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_REPORT = 3'd4
   } sched_state_t;

   // Detector states are named by the longest matched prefix of the pattern.
   typedef enum logic [2:0] {
      DET_S0 = 3'd0,
      DET_S1 = 3'd1,
      DET_S10 = 3'd2,
      DET_S101 = 3'd3,
      DET_S1011 = 3'd4
   } det_state_t;
endpackage

// File: rtl/sd_core.sv
// Moore overlapping "1011" detector; advances on en, returns to the empty
// prefix on clr (clr wins over en).
module sd_core
   import sd_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   input  logic bit_in,
   output logic hit
);

   det_state_t state_r;
   det_state_t state_nxt_s;
   logic       hit_r;

   // Next detector state from the current prefix and the incoming bit.
   always_comb begin
      state_nxt_s = state_r;
      if (clr) begin
         state_nxt_s = DET_S0;
      end else if (en) begin
         case (state_r)
            DET_S0:    state_nxt_s = bit_in ? DET_S1    : DET_S0;
            DET_S1:    state_nxt_s = bit_in ? DET_S1    : DET_S10;
            DET_S10:   state_nxt_s = bit_in ? DET_S101  : DET_S0;
            DET_S101:  state_nxt_s = bit_in ? DET_S1011 : DET_S10;
            DET_S1011: state_nxt_s = bit_in ? DET_S1    : DET_S10;
            default:   state_nxt_s = DET_S0;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // State register; hit is the registered decode of the full-match state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= DET_S0;
         hit_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         hit_r   <= (state_nxt_s == DET_S1011);
      end
   end

   assign hit = hit_r;

endmodule

// File: rtl/sd_sched.sv
// Round-robin scheduler: latches one requester's word, streams it MSB first
// through the detector core and reports the number of "1011" matches.
module sd_sched
   import sd_pkg::*;
#(
   parameter int NREQ   = NREQ_DEF,
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*WORD_W-1:0]   data,
   output logic [NREQ-1:0]          grant,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(NREQ)-1:0]  done_id,
   output logic [CNT_W-1:0]         match_cnt
);

   localparam int ID_W = $clog2(NREQ);
   localparam int BC_W = $clog2(WORD_W);
   localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   sched_state_t      state_r;
   sched_state_t      state_nxt_s;
   logic [NREQ-1:0]   grant_r;
   logic              busy_r;
   logic              done_r;
   logic [ID_W-1:0]   done_id_r;
   logic [CNT_W-1:0]  match_cnt_r;
   logic [ID_W-1:0]   last_id_r;
   logic [WORD_W-1:0] shift_r;
   logic [BC_W-1:0]   bit_cnt_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              fed_r;
   logic              win_found_s;
   logic [ID_W-1:0]   win_id_s;
   logic              core_clr_s;
   logic              core_en_s;
   logic              core_hit_s;

   sd_core u_core (
      .clock   (clock),
      .reset_n (reset_n),
      .clr     (core_clr_s),
      .en      (core_en_s),
      .bit_in  (shift_r[WORD_W-1]),
      .hit     (core_hit_s)
   );

   // Round-robin search starting just after the last granted requester.
   always_comb begin
      logic [ID_W-1:0] cand;
      cand        = {ID_W{1'b0}};
      win_found_s = 1'b0;
      win_id_s    = {ID_W{1'b0}};
      for (int k = 1; k <= NREQ; k++) begin
         cand = ID_W'((int'(last_id_r) + k) % NREQ);
         if (!win_found_s && req[cand]) begin
            win_found_s = 1'b1;
            win_id_s    = cand;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Scheduler next state and detector control.
   always_comb begin
      state_nxt_s = state_r;
      core_clr_s  = 1'b0;
      core_en_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (win_found_s) state_nxt_s = ST_LOAD;
            else             state_nxt_s = ST_IDLE;
         end
         ST_LOAD: begin
            core_clr_s  = 1'b1;
            state_nxt_s = ST_SHIFT;
         end
         ST_SHIFT: begin
            core_en_s = 1'b1;
            if (bit_cnt_r == LAST_BIT) state_nxt_s = ST_DRAIN;
            else                       state_nxt_s = ST_SHIFT;
         end
         ST_DRAIN:  state_nxt_s = ST_REPORT;
         ST_REPORT: begin
            if (win_found_s) state_nxt_s = ST_LOAD;
            else             state_nxt_s = ST_IDLE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // A hit only counts when the cycle before actually fed a bit.
   always_comb begin
      if (core_hit_s && fed_r && (cnt_r != CNT_MAX)) begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         grant_r     <= {NREQ{1'b0}};
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         done_id_r   <= {ID_W{1'b0}};
         match_cnt_r <= {CNT_W{1'b0}};
         last_id_r   <= ID_W'(NREQ - 1);
         shift_r     <= {WORD_W{1'b0}};
         bit_cnt_r   <= {BC_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         fed_r       <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= (state_r == ST_DRAIN);
         fed_r   <= core_en_s;
         if (state_nxt_s == ST_LOAD) begin
            grant_r   <= {{(NREQ-1){1'b0}}, 1'b1} << win_id_s;
            last_id_r <= win_id_s;
         end else begin
            grant_r   <= {NREQ{1'b0}};
         end
         case (state_r)
            ST_LOAD: begin
               shift_r   <= data[int'(last_id_r)*WORD_W +: WORD_W];
               bit_cnt_r <= {BC_W{1'b0}};
               cnt_r     <= {CNT_W{1'b0}};
            end
            ST_SHIFT: begin
               shift_r   <= {shift_r[WORD_W-2:0], 1'b0};
               bit_cnt_r <= bit_cnt_r + {{(BC_W-1){1'b0}}, 1'b1};
               cnt_r     <= cnt_nxt_s;
            end
            ST_DRAIN: begin
               cnt_r       <= cnt_nxt_s;
               match_cnt_r <= cnt_nxt_s;
               done_id_r   <= last_id_r;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign grant     = grant_r;
   assign busy      = busy_r;
   assign done      = done_r;
   assign done_id   = done_id_r;
   assign match_cnt = match_cnt_r;

endmodule

// File: tb/tb_sd_sched.sv
// Randomised scoreboard bench for sd_sched with a transaction-level timing
// and pattern-count reference model.
module tb_sd_sched;
   import sd_pkg::*;

   localparam int NREQ   = NREQ_DEF;
   localparam int WORD_W = WORD_W_DEF;
   localparam int CNT_W  = CNT_W_DEF;
   localparam int ID_W   = $clog2(NREQ);
   localparam int SVC    = WORD_W + 3;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic                    clock = 1'b0;
   logic                    reset_n;
   logic [NREQ-1:0]         req;
   logic [NREQ*WORD_W-1:0]  data;
   logic [NREQ-1:0]         grant;
   logic                    busy;
   logic                    done;
   logic [ID_W-1:0]         done_id;
   logic [CNT_W-1:0]        match_cnt;

   sd_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .data(data),
      .grant(grant), .busy(busy), .done(done), .done_id(done_id),
      .match_cnt(match_cnt)
   );

   always #5 clock = ~clock;

   typedef struct { int id; int cnt; } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   int n_cmp = 0;
   int n_bad = 0;
   int left, last_id, cur_cnt, exp_match;
   int rel [NREQ];
   logic [NREQ-1:0] sticky;
   logic [NREQ-1:0] exp_grant;
   logic exp_busy, exp_done;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Sliding 4-bit window over the word, MSB first, overlapping, saturated.
   function automatic int pattern_hits(input logic [WORD_W-1:0] w);
      int n;
      logic [3:0] pat;
      n = 0;
      pat = PATTERN;
      for (int j = WORD_W - 1; j >= 3; j--)
         if (w[j -: 4] == pat) n++;
      if (n > CMAX) n = CMAX;
      return n;
   endfunction

   task automatic model_reset();
      left = 0; last_id = NREQ - 1; cur_cnt = 0; exp_match = 0;
      exp_grant = '0; exp_busy = 1'b0; exp_done = 1'b0;
      for (int i = 0; i < NREQ; i++) rel[i] = 0;
      sb_q.delete();
   endtask

   // Predict the effect of the coming rising edge. A word occupies SVC cycles
   // from its grant; arbitration happens when idle or in the final cycle.
   task automatic model_step();
      int w;
      bit found;
      exp_grant = '0;
      if (left > 1) begin
         left--;
      end else begin
         found = 1'b0;
         for (int k = 1; k <= NREQ; k++) begin
            w = (last_id + k) % NREQ;
            if (!found && req[w]) begin
               found = 1'b1;
               last_id = w;
            end
         end
         if (found) begin
            left = SVC;
            exp_grant[last_id] = 1'b1;
            rel[last_id] = 2;
            cur_cnt = pattern_hits(data[last_id*WORD_W +: WORD_W]);
            sb_q.push_back('{id: last_id, cnt: cur_cnt});
         end else begin
            left = 0;
         end
      end
      exp_busy = (left != 0);
      exp_done = (left == 1);
      if (left == 1) exp_match = cur_cnt;
   endtask

   task automatic check_outputs();
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("match_cnt_hold", 32'(match_cnt), 32'(exp_match));
   endtask

   // Requesters keep req and data through their grant cycle, then drop req.
   task automatic auto_release();
      for (int i = 0; i < NREQ; i++) begin
         if (rel[i] > 0) begin
            rel[i]--;
            if (rel[i] == 0 && !sticky[i]) req[i] = 1'b0;
         end
      end
   endtask

   task automatic step_cycle();
      model_step();
      @(negedge clock);
      check_outputs();
      auto_release();
   endtask

   task automatic serve(input int i, input logic [WORD_W-1:0] w);
      data[i*WORD_W +: WORD_W] = w;
      req[i] = 1'b1;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((left != 0 || req != '0) && k < 300) begin
         step_cycle();
         k++;
      end
      if (k >= 300) begin
         n_cmp++; n_bad++;
         $display("FAIL drain_timeout: left=%0d req=%b", left, req);
      end
   endtask

   // Scoreboard monitor: every done pulse retires the oldest expected word.
   always @(negedge clock) begin
      if (reset_n === 1'b1 && done === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL done_unexpected: got done_id %0d expected no done", done_id);
         end else begin
            mon_e = sb_q.pop_front();
            chk("done_id", 32'(done_id), 32'(mon_e.id));
            chk("match_cnt_at_done", 32'(match_cnt), 32'(mon_e.cnt));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; req = '0; data = '0; sticky = '0;
      model_reset();
      repeat (2) @(negedge clock);
      check_outputs();
      chk("reset_done_id", 32'(done_id), 32'd0);
      reset_n = 1'b1;

      serve(0, 8'b1011_0110); drain();
      serve(0, 8'h00); drain();
      serve(0, 8'hFF); drain();
      serve(0, 8'b1010_1011); drain();
      serve(0, 8'b1011_1011); drain();

      for (int i = 0; i < NREQ; i++) serve(i, WORD_W'($urandom));
      drain();

      sticky = 4'b1010;
      serve(1, 8'b1101_1011);
      serve(3, 8'b0101_1010);
      repeat (5 * SVC) step_cycle();
      sticky = '0;
      req = '0;
      drain();

      serve(0, 8'b1011_0110);
      repeat (5) step_cycle();
      reset_n = 1'b0;
      #1;
      chk("midrst_grant", 32'(grant), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_match_cnt", 32'(match_cnt), 32'd0);
      model_reset();
      req = '0;
      @(negedge clock);
      check_outputs();
      reset_n = 1'b1;
      serve(0, 8'b0010_1101);
      drain();

      serve(0, 8'b1011_1100);
      repeat (3) step_cycle();
      serve(2, 8'b1011_0000);
      for (int k = 0; k < 2 * SVC && left != 1; k++) step_cycle();
      req[2] = 1'b0;
      drain();

      repeat (700) begin
         for (int i = 0; i < NREQ; i++) begin
            if (rel[i] == 0) begin
               if (!req[i] && $urandom_range(0, 5) == 0)
                  serve(i, WORD_W'($urandom));
               else if (req[i] && $urandom_range(0, 19) == 0)
                  req[i] = 1'b0;
            end
         end
         step_cycle();
      end
      drain();

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sd_sched.md
SD_SCHED -- requirements
Module: sd_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter WORD_W, default 8, bits per serviced word.
REQ-003 Parameter CNT_W, default 4, width of match count.
REQ-004 Port clock  in  1  sole clock, rising edge.
REQ-005 Port reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port req  in  NREQ  per-requester service request, level.
REQ-007 Port data  in  NREQ*WORD_W  word of requester i in bits [i*WORD_W +: WORD_W].
REQ-008 Port grant  out  NREQ  one-hot, high one cycle when requester's word is latched.
REQ-009 Port busy  out  1  high in every state except IDLE.
REQ-010 Port done  out  1  one-cycle pulse, result valid.
REQ-011 Port done_id  out  clog2(NREQ)  index of serviced requester, valid with done.
REQ-012 Port match_cnt  out  CNT_W  overlapping "1011" detections in serviced word; held until next done.

Function
REQ-013 FSM states IDLE, LOAD, SHIFT, DRAIN, REPORT; all transitions on rising clock.
REQ-014 IDLE: any req high -> LOAD, else stay.
REQ-015 Arbitration is round-robin, evaluated in IDLE and REPORT: search starts at (last granted index + 1) mod NREQ; first requester with req high wins.
REQ-016 LOAD (1 cycle): grant[winner]=1; data word of winner latched into shift register at end of cycle; detector core synchronously cleared to its initial state; bit counter and match counter cleared.
REQ-017 SHIFT (exactly WORD_W cycles): one bit per cycle fed to detector core, MSB first; -> DRAIN after bit WORD_W-1.
REQ-018 DRAIN (1 cycle): no bit fed; captures the Moore detector output produced by the final bit.
REQ-019 Match counter increments in each cycle where detector hit is high and the previous cycle fed a bit; hit while a bit is being fed in the first SHIFT cycle is ignored.
REQ-020 Match counter saturates at 2^CNT_W-1.
REQ-021 REPORT (1 cycle): done=1, done_id=serviced index, match_cnt updated from counter; any req high -> LOAD, else -> IDLE.
REQ-022 Fixed service time: LOAD to REPORT inclusive = WORD_W+3 cycles; back-to-back words every WORD_W+3 cycles.
REQ-023 Requester holds req and data stable until it sees its grant; may drop req in the cycle after grant; req dropped before grant is not serviced.
REQ-024 req changes during SHIFT/DRAIN have no effect on the word in progress; they are considered at the next REPORT.
REQ-025 Detection is overlapping: after "1011", a following "011" yields another hit; a following "0" continues from the "10" state.
REQ-026 Detector state does not carry between words; each word starts from the cleared state.

Reset
REQ-027 reset_n low asynchronously forces IDLE, grant=0, busy=0, done=0, done_id=0, match_cnt=0, counters and shift register 0, detector core cleared, round-robin pointer such that requester 0 has highest priority.
REQ-028 Reset mid-operation aborts the word in progress with no done pulse; after release the aborted requester must re-request.

Structure
REQ-029 Shared package sd_pkg holds: scheduler state encoding, detector state encoding, target pattern constant 4'b1011, default NREQ/WORD_W/CNT_W.
REQ-030 Single sub-module sd_core: ports clock, reset_n, clr, en, bit_in, hit; Moore 5-state "1011" overlapping detector, advances only when en=1, returns to initial state on clr.
REQ-031 All outputs of sd_sched are registered.

Verification
REQ-032 Reset, req=4'b0001, data0=8'b1011_0110 in cycle 0 -> grant=0001 in cycle 1, done in cycle 11, done_id=0, match_cnt=2.
REQ-033 data0=8'h00 and then 8'hFF -> match_cnt=0 both; data0=8'b1010_1011 -> match_cnt=1.
REQ-034 All four req high after reset, held until grant -> grants 0,1,2,3 in order, done pulses 11 cycles apart, busy never drops.
REQ-035 req1 and req3 held continuously -> service order alternates 1,3,1,3; no grant to 0 or 2.
REQ-036 reset_n pulsed low during 4th SHIFT cycle -> grant, busy, done, match_cnt all 0 immediately; no done; after release with req high, servicing restarts at LOAD.
REQ-037 req2 dropped one cycle before its grant would occur while req0 being serviced -> requester 2 never granted; FSM returns to IDLE after REPORT.
